aska_spi_master: RTL and testbench
==================================

Name: aska_spi_master

Overview:
- Controller-side SPI initiator that writes one ASKA configuration frame (conf0, conf1, ele1, ele2) into the chip's SPI slave.
- Generates mode-0 SPI_CS / SPI_Clk / SPI_MOSI from a single system clock.
- Sits in the test/host FPGA or an on-chip bring-up controller.
- Its serial output is wired directly to the SPI_CS, SPI_Clk and SPI_MOSI pins of aska_dig.

Parameters:
- CLK_DIV, 4, SPI_Clk half-period in clk cycles. Legal range 1..255; SPI_Clk frequency = clk / (2*CLK_DIV).
- GAP_CYC, 4, minimum clk cycles SPI_CS stays high after a frame before the next frame may start. Legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  request one frame; sampled only in IDLE.
- conf0  in  32  configuration word 0; snapshotted when start is accepted.
- conf1  in  32  configuration word 1; snapshotted when start is accepted.
- ele1  in  32  electrode word 1; snapshotted when start is accepted.
- ele2  in  32  electrode word 2; snapshotted when start is accepted.
- SPI_CS  out  1  chip select, active low.
- SPI_Clk  out  1  SPI clock; idles low (mode 0).
- SPI_MOSI  out  1  serial data; changes only while SPI_Clk is low.
- busy  out  1  high from the cycle after start is accepted through the last GAP cycle.
- done  out  1  one-cycle pulse when the frame, including GAP, has completed.

Behaviour:
- Reset (async, resetn=0): SPI_CS=1, SPI_Clk=0, SPI_MOSI=0, busy=0, done=0. State=IDLE; shift register, bit counter and divider are cleared. All outputs are registered.
- Frame format: 128 bits, MSB first, in the order conf0[31]..conf0[0], conf1[31..0], ele1[31..0], ele2[31..0]. Exactly 128 SPI_Clk rising edges per frame.
- Start acceptance: start=1 in IDLE at clock edge t loads the 128-bit snapshot. At t+1 the block enters LEAD with SPI_CS=0, SPI_MOSI=bit127 and busy=1. start is ignored whenever busy=1 or done=1.
- States and transitions:
  - IDLE: waits for start.
  - LEAD: CLK_DIV cycles with SPI_Clk=0, then HIGH.
  - HIGH: SPI_Clk=1 for CLK_DIV cycles; the slave samples on the rising edge.
  - LOW: SPI_Clk=0 for CLK_DIV cycles. The shift register advances on the first LOW cycle, so MOSI changes on the falling edge. After LOW the block goes back to HIGH if bits remain.
  - After bit 0's HIGH phase the block goes to TRAIL instead of LOW.
  - TRAIL: SPI_Clk=0 and SPI_CS=0 for CLK_DIV cycles. SPI_MOSI holds bit 0.
  - GAP: SPI_CS=1 and SPI_MOSI=0 for GAP_CYC cycles. busy stays 1.
  - DONE: one cycle with done=1, busy=0 and SPI_CS=1, then IDLE.
- Frame length from the first busy cycle through the last GAP cycle = CLK_DIV + 128*2*CLK_DIV - CLK_DIV + CLK_DIV + GAP_CYC. (The final bit has no LOW phase; TRAIL replaces it.)
- Bit counter: 7 bits, counts down 127..0. Terminal detect is at count 0 in HIGH. Counters saturate; they never wrap.
- Divider: 8-bit down-counter reloaded at each phase change. A phase lasts exactly CLK_DIV cycles, including CLK_DIV=1 (SPI_Clk = clk/2).
- Input changes during busy have no effect on the frame in flight.
- Reset mid-frame: outputs go to their reset values immediately, asynchronously. SPI_CS rising aborts the transfer at the slave; no done pulse is produced.
- start held high continuously: one frame per DONE. The next frame starts with LEAD at DONE+2 (start is sampled in IDLE).

Decomposition:
- Shared package aska_spi_pkg holds:
  - FRAME_BITS=128 and WORD_BITS=32.
  - Word order indices: CONF0=0, CONF1=1, ELE1=2, ELE2=3. The slave uses the same definitions.
  - State encoding localparams: IDLE, LEAD, HIGH, LOW, TRAIL, GAP, DONE.
- One natural sub-module: aska_spi_tick, the CLK_DIV phase counter producing a one-cycle phase_end strobe with a reload input. The FSM and shift register stay in aska_spi_master.

Test Plan:
- Reset: resetn=0 asynchronously mid-cycle -> SPI_CS=1, SPI_Clk=0, SPI_MOSI=0, busy=0, done=0 at the same instant; they stay there until start.
- Single frame, CLK_DIV=2, GAP_CYC=4, inputs conf0=32'hA5000190, conf1=32'h00D40A01, ele1=32'h00000001, ele2=32'h80000000:
  - Bench mode-0 receiver captures exactly 128 rising edges and reconstructs all four words bit-exact.
  - busy lasts 2+512-2+2+4=518 cycles; done pulses once.
- Start during busy, plus an input change mid-frame: pulse start at cycle 100 of a frame and change conf0 to 32'hFFFFFFFF -> the frame in flight still carries 32'hA5000190, no second frame starts, exactly one done.
- Back-to-back with start held at 1 and CLK_DIV=1: two frames; SPI_CS high for ≥ GAP_CYC+1 cycles between them; each frame has 128 edges; SPI_Clk period = 2 clk.
- Reset mid-frame after 40 bits: SPI_CS rises within the reset cycle, no done. The next full frame is then correct.
- Loopback with aska_dig: a frame with enable bit conf1[20]=1 -> after done, aska_dig's enable=1 and its internal conf0..ele2 registers equal the sent values.

Source files
------------

// File: rtl/aska_spi_pkg.sv
// Shared definitions for the ASKA configuration SPI link (master and slave).
// Frame layout: four 32-bit words, word 0 shifted out first, MSB first.
package aska_spi_pkg;

  localparam int FRAME_BITS = 128;
  localparam int WORD_BITS  = 32;

  localparam int CONF0 = 0;
  localparam int CONF1 = 1;
  localparam int ELE1  = 2;
  localparam int ELE2  = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    TRAIL = 3'd4,
    GAP   = 3'd5,
    DONE  = 3'd6
  } spi_state_e;

  function automatic int word_msb(input int idx);
    return FRAME_BITS - 1 - idx * WORD_BITS;
  endfunction

  function automatic logic [FRAME_BITS-1:0] pack_frame(
    input logic [WORD_BITS-1:0] w_conf0,
    input logic [WORD_BITS-1:0] w_conf1,
    input logic [WORD_BITS-1:0] w_ele1,
    input logic [WORD_BITS-1:0] w_ele2
  );
    logic [FRAME_BITS-1:0] f;
    f = '0;
    f[word_msb(CONF0) -: WORD_BITS] = w_conf0;
    f[word_msb(CONF1) -: WORD_BITS] = w_conf1;
    f[word_msb(ELE1)  -: WORD_BITS] = w_ele1;
    f[word_msb(ELE2)  -: WORD_BITS] = w_ele2;
    return f;
  endfunction

endpackage

// File: rtl/aska_spi_tick.sv
// Phase timer: down-counter reloaded on every phase change; o_phase_end marks
// the last cycle of the current phase (reload value N gives N+1 cycles).
module aska_spi_tick
  import aska_spi_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic       i_reload,
  input  logic [7:0] i_reload_val,
  output logic       o_phase_end
);

  logic [7:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_cnt <= 8'd0;
    end else if (i_reload) begin
      r_cnt <= i_reload_val;
    end else if (r_cnt != 8'd0) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_phase_end = (r_cnt == 8'd0);

endmodule

// File: rtl/aska_spi_master.sv
// Mode-0 SPI initiator sending one 128-bit ASKA configuration frame per start.
// All pins are registered from the next-state decode so they change on one edge.
module aska_spi_master
  import aska_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WORD_BITS-1:0] conf0,
  input  logic [WORD_BITS-1:0] conf1,
  input  logic [WORD_BITS-1:0] ele1,
  input  logic [WORD_BITS-1:0] ele2,
  output logic                 SPI_CS,
  output logic                 SPI_Clk,
  output logic                 SPI_MOSI,
  output logic                 busy,
  output logic                 done
);

  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_RELOAD = 8'(GAP_CYC - 1);
  localparam logic [6:0] LAST_BIT   = 7'(FRAME_BITS - 1);

  spi_state_e            r_state;
  spi_state_e            w_state_nxt;
  logic [FRAME_BITS-1:0] r_shift;
  logic [FRAME_BITS-1:0] w_shift_nxt;
  logic [6:0]            r_bitcnt;
  logic [6:0]            w_bitcnt_nxt;
  logic                  w_reload;
  logic [7:0]            w_reload_val;
  logic                  w_phase_end;
  logic                  w_in_frame;
  logic                  r_cs;
  logic                  r_sclk;
  logic                  r_mosi;
  logic                  r_busy;
  logic                  r_done;

  aska_spi_tick u_tick (
    .i_clk        (clk),
    .i_resetn     (resetn),
    .i_reload     (w_reload),
    .i_reload_val (w_reload_val),
    .o_phase_end  (w_phase_end)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_reload     = 1'b0;
    w_reload_val = DIV_RELOAD;
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt  = LEAD;
          w_reload     = 1'b1;
          w_shift_nxt  = pack_frame(conf0, conf1, ele1, ele2);
          w_bitcnt_nxt = LAST_BIT;
        end
      end
      LEAD: begin
        if (w_phase_end) begin
          w_state_nxt = HIGH;
          w_reload    = 1'b1;
        end
      end
      HIGH: begin
        // Bit 0 skips its LOW phase; TRAIL holds MOSI and CS instead.
        if (w_phase_end) begin
          w_reload = 1'b1;
          if (r_bitcnt == 7'd0) begin
            w_state_nxt = TRAIL;
          end else begin
            w_state_nxt  = LOW;
            w_shift_nxt  = {r_shift[FRAME_BITS-2:0], 1'b0};
            w_bitcnt_nxt = r_bitcnt - 7'd1;
          end
        end
      end
      LOW: begin
        if (w_phase_end) begin
          w_state_nxt = HIGH;
          w_reload    = 1'b1;
        end
      end
      TRAIL: begin
        if (w_phase_end) begin
          w_state_nxt  = GAP;
          w_reload     = 1'b1;
          w_reload_val = GAP_RELOAD;
        end
      end
      GAP: begin
        if (w_phase_end) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_in_frame = (w_state_nxt == LEAD) || (w_state_nxt == HIGH) ||
                      (w_state_nxt == LOW)  || (w_state_nxt == TRAIL);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_shift  <= '0;
      r_bitcnt <= 7'd0;
      r_cs     <= 1'b1;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_shift  <= w_shift_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_cs     <= !w_in_frame;
      r_sclk   <= (w_state_nxt == HIGH);
      r_mosi   <= w_in_frame ? w_shift_nxt[FRAME_BITS-1] : 1'b0;
      r_busy   <= w_in_frame || (w_state_nxt == GAP);
      r_done   <= (w_state_nxt == DONE);
    end
  end

  assign SPI_CS   = r_cs;
  assign SPI_Clk  = r_sclk;
  assign SPI_MOSI = r_mosi;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_aska_spi_master.sv
// Scoreboard bench: stimulus queues expected frames, a mode-0 receiver
// monitor reassembles frames from the pins and compares on SPI_CS release.
`timescale 1ns/1ps
module tb_aska_spi_master;

  localparam logic [31:0] A0 = 32'hA5000190, A1 = 32'h00D40A01, A2 = 32'h00000001, A3 = 32'h80000000;
  localparam logic [31:0] R0 = 32'h0BADF00D, R1 = 32'h13572468, R2 = 32'hCAFEBABE, R3 = 32'h55AA55AA;
  localparam logic [31:0] B0 = 32'hDEADBEEF, B1 = 32'h0F0F0F0F, B2 = 32'hFFFFFFFF, B3 = 32'h00000000;
  localparam logic [31:0] P0 = 32'h12345678, P1 = 32'h9ABCDEF0, P2 = 32'h00000000, P3 = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic [1:0]  rstn = 2'b11;
  logic [1:0]  start_v;
  logic [1:0]  cs, sclk, mosi, busy, done;
  logic [31:0] conf0, conf1, ele1, ele2;

  always #5 clk = ~clk;

  aska_spi_master #(.CLK_DIV(2), .GAP_CYC(4)) u_dut0 (
    .clk(clk), .resetn(rstn[0]), .start(start_v[0]),
    .conf0(conf0), .conf1(conf1), .ele1(ele1), .ele2(ele2),
    .SPI_CS(cs[0]), .SPI_Clk(sclk[0]), .SPI_MOSI(mosi[0]), .busy(busy[0]), .done(done[0])
  );

  aska_spi_master #(.CLK_DIV(1), .GAP_CYC(4)) u_dut1 (
    .clk(clk), .resetn(rstn[1]), .start(start_v[1]),
    .conf0(conf0), .conf1(conf1), .ele1(ele1), .ele2(ele2),
    .SPI_CS(cs[1]), .SPI_Clk(sclk[1]), .SPI_MOSI(mosi[1]), .busy(busy[1]), .done(done[1])
  );

  logic [127:0] q_exp0[$];
  logic [127:0] q_exp1[$];
  string        q_nm[$];
  logic [31:0]  q_act[$];
  logic [31:0]  q_req[$];

  int n_checks = 0;
  int n_err    = 0;
  logic final_req = 1'b0;
  logic final_ack = 1'b0;

  int m_bits[2], hi_run[2], lo_run[2], hi_min[2], hi_max[2], lo_min[2], lo_max[2];
  int lead[2], busy_run[2], gap_run[2], frames[2], done_cnt[2];
  logic [127:0] m_sr[2];
  logic prev_cs[2], prev_sclk[2], prev_busy[2];

  function automatic int cdiv(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int busy_len(input int i);
    return (i == 0) ? 518 : 261;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic frame_end(input int i);
    logic [127:0] e;
    if ((i == 0 && q_exp0.size() == 0) || (i == 1 && q_exp1.size() == 0)) begin
      chk($sformatf("d%0d_unexpected_frame", i), 32'd1, 32'd0);
      return;
    end
    if (i == 0) e = q_exp0.pop_front();
    else        e = q_exp1.pop_front();
    chk($sformatf("d%0d_edges", i), m_bits[i], 32'd128);
    for (int k = 0; k < 4; k++)
      chk($sformatf("d%0d_word%0d", i, k), m_sr[i][127-32*k -: 32], e[127-32*k -: 32]);
    chk($sformatf("d%0d_sclk_high_min_max", i), hi_min[i] * 256 + hi_max[i], cdiv(i) * 257);
    chk($sformatf("d%0d_sclk_low_min_max", i), lo_min[i] * 256 + lo_max[i], cdiv(i) * 257);
    chk($sformatf("d%0d_lead_len", i), lead[i], cdiv(i));
  endtask

  task automatic mon_step(input int i);
    if (rstn[i] !== 1'b1) begin
      m_bits[i] = 0; m_sr[i] = '0; busy_run[i] = 0; gap_run[i] = 0;
      prev_cs[i] = 1'b1; prev_sclk[i] = 1'b0; prev_busy[i] = 1'b0;
      return;
    end
    if (prev_cs[i] && !cs[i]) begin
      if (i == 1 && frames[1] > 0) chk("d1_cs_gap", gap_run[1], 32'd6);
      m_bits[i] = 0; m_sr[i] = '0; lo_run[i] = 0; hi_run[i] = 0; lead[i] = 0;
      hi_min[i] = 255; hi_max[i] = 0; lo_min[i] = 255; lo_max[i] = 0;
    end
    if (!prev_cs[i] && cs[i]) begin
      frame_end(i);
      frames[i]++;
      gap_run[i] = 0;
    end
    if (cs[i]) begin
      gap_run[i]++;
    end else begin
      if (sclk[i] && !prev_sclk[i]) begin
        m_sr[i] = {m_sr[i][126:0], mosi[i]};
        if (m_bits[i] == 0) lead[i] = lo_run[i];
        else begin
          if (lo_run[i] < lo_min[i]) lo_min[i] = lo_run[i];
          if (lo_run[i] > lo_max[i]) lo_max[i] = lo_run[i];
        end
        m_bits[i]++;
        lo_run[i] = 0;
        hi_run[i] = 0;
      end
      if (!sclk[i] && prev_sclk[i]) begin
        if (hi_run[i] < hi_min[i]) hi_min[i] = hi_run[i];
        if (hi_run[i] > hi_max[i]) hi_max[i] = hi_run[i];
        hi_run[i] = 0;
      end
      if (sclk[i]) hi_run[i]++;
      else         lo_run[i]++;
    end
    if (busy[i] && !prev_busy[i]) busy_run[i] = 0;
    if (busy[i]) busy_run[i]++;
    if (!busy[i] && prev_busy[i]) begin
      chk($sformatf("d%0d_busy_len", i), busy_run[i], busy_len(i));
      chk($sformatf("d%0d_done_at_busy_fall", i), 32'(done[i]), 32'd1);
    end
    if (done[i]) done_cnt[i]++;
    prev_cs[i] = cs[i]; prev_sclk[i] = sclk[i]; prev_busy[i] = busy[i];
  endtask

  always @(negedge clk) begin
    while (q_nm.size() > 0) chk(q_nm.pop_front(), q_act.pop_front(), q_req.pop_front());
    for (int i = 0; i < 2; i++) mon_step(i);
    if (final_req && !final_ack) begin
      chk("d0_done_count", done_cnt[0], 32'd3);
      chk("d1_done_count", done_cnt[1], 32'd2);
      chk("d0_frames_left", q_exp0.size(), 32'd0);
      chk("d1_frames_left", q_exp1.size(), 32'd0);
      final_ack = 1'b1;
    end
  end

  task automatic push_imm(input string nm, input logic [31:0] act, input logic [31:0] req);
    q_nm.push_back(nm);
    q_act.push_back(act);
    q_req.push_back(req);
  endtask

  task automatic set_words(input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
    conf0 = w0; conf1 = w1; ele1 = w2; ele2 = w3;
  endtask

  task automatic pulse_start0();
    @(posedge clk); #1 start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
  endtask

  task automatic wait_busy(input int i, input logic lvl, input int lim, input string nm);
    int n;
    n = 0;
    while (busy[i] !== lvl && n < lim) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy[i] !== lvl) push_imm(nm, 32'(busy[i]), 32'(lvl));
  endtask

  initial begin
    start_v = 2'b00;
    set_words(32'd0, 32'd0, 32'd0, 32'd0);
    #1 rstn = 2'b00;
    #2;
    push_imm("d0_reset_outputs", 32'({cs[0], sclk[0], mosi[0], busy[0], done[0]}), 32'b10000);
    push_imm("d1_reset_outputs", 32'({cs[1], sclk[1], mosi[1], busy[1], done[1]}), 32'b10000);
    repeat (3) @(posedge clk);
    #1 rstn = 2'b11;
    repeat (2) @(posedge clk);

    set_words(A0, A1, A2, A3);
    q_exp0.push_back({A0, A1, A2, A3});
    pulse_start0();
    wait_busy(0, 1'b1, 5, "f1_busy_rise_timeout");
    wait_busy(0, 1'b0, 600, "f1_busy_fall_timeout");
    repeat (3) @(posedge clk);

    q_exp0.push_back({A0, A1, A2, A3});
    pulse_start0();
    repeat (99) @(posedge clk);
    #1 start_v[0] = 1'b1;
    conf0 = 32'hFFFFFFFF;
    @(posedge clk); #1 start_v[0] = 1'b0;
    wait_busy(0, 1'b0, 600, "f2_busy_fall_timeout");
    repeat (6) @(posedge clk);

    set_words(R0, R1, R2, R3);
    pulse_start0();
    repeat (162) @(posedge clk);
    #2 rstn[0] = 1'b0;
    #1 push_imm("d0_reset_midframe", 32'({cs[0], sclk[0], mosi[0], busy[0], done[0]}), 32'b10000);
    repeat (2) @(posedge clk);
    #1 rstn[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 push_imm("d0_reset_hold", 32'({cs[0], sclk[0], mosi[0], busy[0], done[0]}), 32'b10000);

    set_words(B0, B1, B2, B3);
    q_exp0.push_back({B0, B1, B2, B3});
    pulse_start0();
    wait_busy(0, 1'b0, 600, "f4_busy_fall_timeout");
    repeat (4) @(posedge clk);

    set_words(P0, P1, P2, P3);
    q_exp1.push_back({P0, P1, P2, P3});
    q_exp1.push_back({A0, A1, A2, A3});
    @(posedge clk); #1 start_v[1] = 1'b1;
    wait_busy(1, 1'b1, 5, "b2b_first_rise_timeout");
    set_words(A0, A1, A2, A3);
    wait_busy(1, 1'b0, 400, "b2b_first_fall_timeout");
    wait_busy(1, 1'b1, 10, "b2b_second_rise_timeout");
    start_v[1] = 1'b0;
    wait_busy(1, 1'b0, 400, "b2b_second_fall_timeout");
    repeat (5) @(posedge clk);

    final_req = 1'b1;
    for (int n = 0; n < 10 && !final_ack; n++) @(posedge clk);
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
